// File: rtl/down_sram_drain_pkg.sv
// down_sram_drain_pkg: FSM state encoding and SRAM geometry helper shared by the drain engine.
package down_sram_drain_pkg;
  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_SEND, S_DONE} state_t;
  function automatic int unsigned sram_depth(input int unsigned log2_depth);
    return 32'd1 << log2_depth;
  endfunction
endpackage

// File: rtl/row_serializer.sv
// row_serializer: holds one result row and streams its columns as valid/ready words.
module row_serializer #(
  parameter int NUM_COL = 4,
  parameter int OUT_DATA_WIDTH = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] row_in,
  input  logic                              final_in,
  input  logic                              ready,
  output logic [OUT_DATA_WIDTH-1:0]         data,
  output logic                              valid,
  output logic                              last,
  output logic                              fire_last
);
  localparam int CW = $clog2(NUM_COL);
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] row;
  logic [CW-1:0] col;
  logic final_row, end_col;
  assign end_col = col == CW'(NUM_COL - 1);
  assign data = row[col*OUT_DATA_WIDTH +: OUT_DATA_WIDTH];
  assign last = valid & final_row & end_col;
  assign fire_last = valid & ready & end_col;
  // a load on the last-column handshake keeps valid high for a gapless stream
  always_ff @(posedge clk)
    if (rst) begin
      row <= '0;
      col <= '0;
      valid <= 1'b0;
      final_row <= 1'b0;
    end else if (load) begin
      row <= row_in;
      col <= '0;
      valid <= 1'b1;
      final_row <= final_in;
    end else if (valid & ready) begin
      col <= end_col ? '0 : col + 1'b1;
      valid <= ~end_col;
    end
endmodule

// File: rtl/down_sram_drain.sv
// down_sram_drain: walks a down-SRAM row range and streams each row as single accumulator words.
// Define DOWN_DRAIN_PREFETCH_EN to add a prefetch row register for a gapless stream.
module down_sram_drain
  import down_sram_drain_pkg::*;
#(
  parameter int NUM_COL = 4,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int LOG2_SRAM_BANK_DEPTH = 5
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_rd_start_addr,
  input  logic [LOG2_SRAM_BANK_DEPTH-1:0]   i_rd_end_addr,
  output logic                              o_down_rd_en,
  output logic [LOG2_SRAM_BANK_DEPTH-1:0]   o_down_rd_addr,
  input  logic [NUM_COL*OUT_DATA_WIDTH-1:0] i_down_rd_data,
  output logic [OUT_DATA_WIDTH-1:0]         o_data,
  output logic                              o_valid,
  input  logic                              i_ready,
  output logic                              o_last,
  output logic                              o_busy,
  output logic                              o_done
);
  state_t state;
  logic [LOG2_SRAM_BANK_DEPTH-1:0] end_addr;
  logic load, fire_last, final_in;
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] row_in;
  // o_down_rd_addr always names the newest row read, which is the row being loaded
  assign final_in = o_down_rd_addr == end_addr;
`ifdef DOWN_DRAIN_PREFETCH_EN
  logic [NUM_COL*OUT_DATA_WIDTH-1:0] pf_data;
  logic pf_valid, pf_pend;
  assign load = state == S_WAIT || (state == S_SEND && fire_last && !o_last);
  // bypass the prefetch register when its read returns on the handshake cycle
  assign row_in = (state == S_SEND && pf_valid) ? pf_data : i_down_rd_data;
  always_ff @(posedge clk)
    if (rst) begin
      pf_data <= '0;
      pf_valid <= 1'b0;
      pf_pend <= 1'b0;
    end else begin
      pf_pend <= o_down_rd_en & (state == S_SEND);
      if (pf_pend) pf_data <= i_down_rd_data;
      pf_valid <= (pf_valid | pf_pend) & ~load;
    end
`else
  assign load = state == S_WAIT;
  assign row_in = i_down_rd_data;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_IDLE;
      end_addr <= '0;
      o_down_rd_en <= 1'b0;
      o_down_rd_addr <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      o_down_rd_en <= 1'b0;
      o_done <= 1'b0;
      case (state)
        S_IDLE: if (i_start) begin
          state <= S_READ;
          o_down_rd_addr <= i_rd_start_addr;
          end_addr <= i_rd_end_addr;
          o_down_rd_en <= 1'b1;
          o_busy <= 1'b1;
        end
        S_READ: state <= S_WAIT;
        S_WAIT: begin
          state <= S_SEND;
`ifdef DOWN_DRAIN_PREFETCH_EN
          if (!final_in) begin
            o_down_rd_en <= 1'b1;
            o_down_rd_addr <= o_down_rd_addr + 1'b1;
          end
`endif
        end
        S_SEND:
          if (fire_last & o_last) begin
            state <= S_DONE;
            o_done <= 1'b1;
          end
`ifdef DOWN_DRAIN_PREFETCH_EN
          else if (load & ~final_in) begin
            o_down_rd_en <= 1'b1;
            o_down_rd_addr <= o_down_rd_addr + 1'b1;
          end
`else
          else if (fire_last) begin
            state <= S_READ;
            o_down_rd_en <= 1'b1;
            o_down_rd_addr <= o_down_rd_addr + 1'b1;
          end
`endif
        S_DONE: begin
          state <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  row_serializer #(.NUM_COL(NUM_COL), .OUT_DATA_WIDTH(OUT_DATA_WIDTH)) u_ser (
    .clk(clk),
    .rst(rst),
    .load(load),
    .row_in(row_in),
    .final_in(final_in),
    .ready(i_ready),
    .data(o_data),
    .valid(o_valid),
    .last(o_last),
    .fire_last(fire_last)
  );
endmodule
